// File: rtl/otter_intc_pkg.sv
// Otter platform interrupt controller: shared register map and helpers.
// Word offsets are bus_addr[4:2]; ID 0 means no source.
package otter_intc_pkg;

    localparam logic [2:0] INTC_PENDING   = 3'd0;
    localparam logic [2:0] INTC_ENABLE    = 3'd1;
    localparam logic [2:0] INTC_TRIGGER   = 3'd2;
    localparam logic [2:0] INTC_CLAIM     = 3'd3;
    localparam logic [2:0] INTC_INSERVICE = 3'd4;

    localparam logic [4:0] INTC_ID_NONE = 5'd0;

    // Lowest set bit wins; bit i maps to ID i+1.
    function automatic logic [4:0] first_id(input logic [30:0] v);
        first_id = INTC_ID_NONE;
        for (int i = 30; i >= 0; i--) begin
            if (v[i]) first_id = 5'(i + 1);
        end
    endfunction

endpackage

// File: rtl/otter_intc_gateway.sv
// Per-source gateway: two-flop synchroniser plus rising-edge detect.
// level_o is the synchronised request, rise_o a one-cycle pulse.
module otter_intc_gateway (
    input  logic clk,
    input  logic rst,
    input  logic irq_i,
    output logic level_o,
    output logic rise_o
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;

    // Synchronise the async request and keep one cycle of history.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= irq_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign level_o = sync2_q;
    assign rise_o  = sync2_q & ~prev_q;

endmodule

// File: rtl/otter_intc.sv
// Otter platform interrupt controller: pending/enable/trigger/in-service
// state, lowest-ID priority claim and MMIO claim/complete handshake.
module otter_intc
    import otter_intc_pkg::*;
#(
    parameter int NUM_SRC = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] irq_src,
    input  logic               bus_sel,
    input  logic               bus_rd,
    input  logic               bus_wr,
    input  logic [4:0]         bus_addr,
    input  logic [31:0]        bus_wdata,
    output logic [31:0]        bus_rdata,
    output logic               ext_intrpt
);

    logic [NUM_SRC-1:0] lvl;
    logic [NUM_SRC-1:0] rise;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_gw
        otter_intc_gateway u_gw (
            .clk     (clk),
            .rst     (rst),
            .irq_i   (irq_src[g]),
            .level_o (lvl[g]),
            .rise_o  (rise[g])
        );
    end

    logic [NUM_SRC-1:0] pending_q, pending_d;
    logic [NUM_SRC-1:0] enable_q, enable_d;
    logic [NUM_SRC-1:0] trigger_q, trigger_d;
    logic [NUM_SRC-1:0] insvc_q, insvc_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               ext_q;

    logic               rd_en, wr_en;
    logic [2:0]         reg_sel;
    logic               claim_en, complete_en, comp_valid;
    logic [NUM_SRC-1:0] claimable, claim_oh, comp_oh;
    logic [NUM_SRC-1:0] wdata_lo, trig_chg;
    logic [4:0]         claim_id, comp_idx;
    logic               unused_addr;

    assign unused_addr = ^bus_addr[1:0];

    assign rd_en   = bus_sel & bus_rd;
    assign wr_en   = bus_sel & bus_wr;
    assign reg_sel = bus_addr[4:2];

    // A simultaneous write at CLAIM is a complete; the claim is suppressed.
    assign claim_en    = rd_en & ~wr_en & (reg_sel == INTC_CLAIM);
    assign complete_en = wr_en & (reg_sel == INTC_CLAIM);

    assign claimable = pending_q & enable_q & ~insvc_q;
    assign claim_id  = first_id(31'(claimable));
    assign claim_oh  = claim_en ? (claimable & ~(claimable - 1'b1)) : '0;

    assign wdata_lo   = bus_wdata[NUM_SRC-1:0];
    assign comp_idx   = bus_wdata[4:0] - 5'd1;
    assign comp_valid = complete_en && (bus_wdata != 32'd0) &&
                        (bus_wdata <= 32'(NUM_SRC));
    assign comp_oh    = comp_valid ? (NUM_SRC'(1) << comp_idx) : '0;

    assign trig_chg = (wr_en && reg_sel == INTC_TRIGGER) ?
                      (trigger_q ^ wdata_lo) : '0;

    // Edge sources: rise sets (beats claim clear). Level sources follow sync.
    assign pending_d = ~trig_chg &
                       ((trigger_q & (rise | (pending_q & ~claim_oh))) |
                        (~trigger_q & lvl));

    // Register writes, in-service tracking and registered read data.
    always_comb begin
        enable_d  = enable_q;
        trigger_d = trigger_q;
        insvc_d   = (insvc_q | claim_oh) & ~comp_oh;
        rdata_d   = rdata_q;
        if (wr_en && reg_sel == INTC_ENABLE)  enable_d  = wdata_lo;
        if (wr_en && reg_sel == INTC_TRIGGER) trigger_d = wdata_lo;
        if (rd_en) begin
            unique case (reg_sel)
                INTC_PENDING:   rdata_d = 32'(pending_q);
                INTC_ENABLE:    rdata_d = 32'(enable_q);
                INTC_TRIGGER:   rdata_d = 32'(trigger_q);
                INTC_CLAIM:     rdata_d = claim_en ? 32'(claim_id) : 32'd0;
                INTC_INSERVICE: rdata_d = 32'(insvc_q);
                default:        rdata_d = 32'd0;
            endcase
        end
    end

    // State update; ext_intrpt lags claimable by one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q <= '0;
            enable_q  <= '0;
            trigger_q <= '0;
            insvc_q   <= '0;
            rdata_q   <= '0;
            ext_q     <= 1'b0;
        end else begin
            pending_q <= pending_d;
            enable_q  <= enable_d;
            trigger_q <= trigger_d;
            insvc_q   <= insvc_d;
            rdata_q   <= rdata_d;
            ext_q     <= |claimable;
        end
    end

    assign bus_rdata  = rdata_q;
    assign ext_intrpt = ext_q;

endmodule

// File: tb/tb_otter_intc.sv
// Bench for otter_intc: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a behavioural model.
module tb_otter_intc;

    localparam int N = 8;

    logic         clk;
    logic         rst;
    logic [N-1:0] irq_src;
    logic         bus_sel, bus_rd, bus_wr;
    logic [4:0]   bus_addr;
    logic [31:0]  bus_wdata;
    logic [31:0]  bus_rdata;
    logic         ext_intrpt;

    otter_intc #(.NUM_SRC(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .irq_src    (irq_src),
        .bus_sel    (bus_sel),
        .bus_rd     (bus_rd),
        .bus_wr     (bus_wr),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_rdata  (bus_rdata),
        .ext_intrpt (ext_intrpt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int  checks = 0;
    int  errors = 0;
    bit  live   = 0;

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    // Inputs as seen at the last rising edge.
    bit         c_rst, c_sel, c_rd, c_wr;
    bit [N-1:0] c_irq;
    bit [4:0]   c_addr;
    bit [31:0]  c_wd;

    initial forever begin
        @(posedge clk);
        c_rst  = rst;
        c_irq  = irq_src;
        c_sel  = bus_sel;
        c_rd   = bus_rd;
        c_wr   = bus_wr;
        c_addr = bus_addr;
        c_wd   = bus_wdata;
    end

    // Behavioural model: irq samples delayed two edges drive the sources.
    bit [N-1:0] m_pend, m_en, m_trig, m_isv;
    bit [31:0]  m_rdata;
    bit         m_ext;
    bit [N-1:0] hist [3];

    initial forever begin
        @(negedge clk);
        if (c_rst) begin
            m_pend = 0; m_en = 0; m_trig = 0; m_isv = 0;
            m_rdata = 0; m_ext = 0;
            for (int k = 0; k < 3; k++) hist[k] = 0;
        end else begin
            bit [N-1:0] lv, rs, cl, claimed, np, nisv;
            int id, off;
            bit w, r;
            lv = hist[1];
            rs = hist[1] & ~hist[2];
            cl = m_pend & m_en & ~m_isv;
            id = 0;
            for (int i = 0; i < N; i++) begin
                if (cl[i]) begin
                    id = i + 1;
                    break;
                end
            end
            w = c_sel & c_wr;
            r = c_sel & c_rd;
            off = int'(c_addr) / 4;
            claimed = 0;
            if (r) begin
                case (off)
                    0: m_rdata = 32'(m_pend);
                    1: m_rdata = 32'(m_en);
                    2: m_rdata = 32'(m_trig);
                    3: begin
                        m_rdata = w ? 0 : id;
                        if (!w && id != 0) claimed[id-1] = 1'b1;
                    end
                    4: m_rdata = 32'(m_isv);
                    default: m_rdata = 0;
                endcase
            end
            for (int i = 0; i < N; i++) begin
                if (w && off == 2 && c_wd[i] != m_trig[i]) np[i] = 0;
                else if (m_trig[i]) np[i] = rs[i] | (m_pend[i] & ~claimed[i]);
                else np[i] = lv[i];
            end
            nisv = m_isv | claimed;
            if (w && off == 3 && c_wd >= 1 && c_wd <= N && m_isv[c_wd-1])
                nisv[c_wd-1] = 1'b0;
            if (w && off == 1) m_en = c_wd[N-1:0];
            if (w && off == 2) m_trig = c_wd[N-1:0];
            m_pend = np;
            m_isv  = nisv;
            m_ext  = (cl != 0);
            hist[2] = hist[1];
            hist[1] = hist[0];
            hist[0] = c_irq;
        end
        if (live) begin
            chk("model_rdata", bus_rdata, m_rdata);
            chk("model_ext", 32'(ext_intrpt), 32'(m_ext));
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus(input bit r, input bit w, input logic [4:0] a,
                       input logic [31:0] d);
        bus_sel = 1; bus_rd = r; bus_wr = w; bus_addr = a; bus_wdata = d;
        @(negedge clk);
        bus_sel = 0; bus_rd = 0; bus_wr = 0;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        bus(0, 1, a, d);
    endtask

    task automatic rd_chk(input string nm, input logic [4:0] a,
                          input logic [31:0] exp);
        bus(1, 0, a, 0);
        chk(nm, bus_rdata, exp);
    endtask

    int ids [3] = '{0, 9, 2};

    initial begin
        rst = 1; irq_src = 0;
        bus_sel = 0; bus_rd = 0; bus_wr = 0; bus_addr = 0; bus_wdata = 0;
        idle(2);
        live = 1;
        chk("reset_rdata", bus_rdata, 0);
        chk("reset_ext", 32'(ext_intrpt), 0);
        rst = 0;

        // Edge source 2.
        wr(5'h04, 32'h04);
        wr(5'h08, 32'h04);
        irq_src[2] = 1;
        idle(1);
        irq_src[2] = 0;
        idle(3);
        chk("edge_ext_rise", 32'(ext_intrpt), 1);
        rd_chk("edge_claim3", 5'h0C, 3);
        idle(1);
        chk("edge_ext_drop", 32'(ext_intrpt), 0);
        rd_chk("edge_pending0", 5'h00, 0);
        rd_chk("edge_insvc4", 5'h10, 32'h04);
        wr(5'h0C, 3);

        // Priority among sources 1 and 5.
        wr(5'h04, 32'h22);
        wr(5'h08, 32'h22);
        irq_src = 8'h22;
        idle(4);
        rd_chk("prio_claim2", 5'h0C, 2);
        rd_chk("prio_claim6", 5'h0C, 6);
        rd_chk("prio_claim0", 5'h0C, 0);
        rd_chk("prio_insvc", 5'h10, 32'h22);
        wr(5'h0C, 2);
        wr(5'h0C, 6);
        irq_src = 0;
        rd_chk("prio_insvc0", 5'h10, 0);

        // Level source 0.
        wr(5'h08, 0);
        wr(5'h04, 1);
        irq_src[0] = 1;
        idle(4);
        rd_chk("lvl_claim1", 5'h0C, 1);
        wr(5'h0C, 1);
        idle(1);
        chk("lvl_reassert", 32'(ext_intrpt), 1);
        irq_src[0] = 0;
        idle(3);
        rd_chk("lvl_claim0", 5'h0C, 0);

        // Bad completes leave in-service alone.
        irq_src[0] = 1;
        idle(4);
        rd_chk("bad_claim1", 5'h0C, 1);
        foreach (ids[k]) begin
            wr(5'h0C, 32'(ids[k]));
            rd_chk($sformatf("bad_complete_%0d", ids[k]), 5'h10, 1);
        end
        wr(5'h0C, 1);
        irq_src[0] = 0;
        idle(3);

        // Edge on source 3 coincident with its claim.
        wr(5'h04, 32'h08);
        wr(5'h08, 32'h08);
        irq_src[3] = 1;
        idle(1);
        irq_src[3] = 0;
        idle(3);
        irq_src[3] = 1;
        idle(2);
        rd_chk("race_claim4", 5'h0C, 4);
        rd_chk("race_pending", 5'h00, 32'h08);
        rd_chk("race_insvc", 5'h10, 32'h08);
        wr(5'h0C, 4);
        rd_chk("race_claim4b", 5'h0C, 4);

        // Reset with a source in service and pending.
        irq_src[3] = 0;
        idle(2);
        irq_src[3] = 1;
        idle(4);
        rd_chk("rst_pre_pending", 5'h00, 32'h08);
        irq_src = 0;
        rst = 1;
        idle(1);
        chk("rst_ext", 32'(ext_intrpt), 0);
        chk("rst_rdata", bus_rdata, 0);
        rst = 0;
        rd_chk("rst_pending", 5'h00, 0);
        rd_chk("rst_enable", 5'h04, 0);
        rd_chk("rst_trigger", 5'h08, 0);
        rd_chk("rst_insvc", 5'h10, 0);

        // Randomized traffic.
        for (int t = 0; t < 4000; t++) begin
            rst = ($urandom_range(0, 399) == 0);
            if ($urandom_range(0, 5) == 0)
                irq_src[$urandom_range(0, N-1)] ^= 1'b1;
            bus_sel = ($urandom_range(0, 3) != 0);
            bus_rd  = $urandom_range(0, 1);
            bus_wr  = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 1) == 0) bus_addr = 5'h0C;
            else bus_addr = 5'($urandom_range(0, 31));
            if (bus_addr[4:2] == 3'd3) bus_wdata = $urandom_range(0, 10);
            else bus_wdata = $urandom;
            @(negedge clk);
        end
        rst = 0; bus_sel = 0; bus_rd = 0; bus_wr = 0;
        idle(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
